// File: rtl/wb_commit_tracer_if.sv
// wb_commit_tracer_if: write-back capture, trace stream and counter signals of the commit tracer.
interface wb_commit_tracer_if #(
  parameter int DEPTH = 8,
  parameter int CYCW  = 32
);
  localparam int OW = $clog2(DEPTH) + 1;
  logic            wb_valid;
  logic [31:0]     wb_pc;
  logic [31:0]     wb_instruction;
  logic [31:0]     wb_write_data;
  logic [4:0]      wb_rd_addr;
  logic            wb_RegWrite;
  logic            clr_overflow;
  logic            trace_valid;
  logic            trace_ready;
  logic [31:0]     trace_pc;
  logic [31:0]     trace_instruction;
  logic [31:0]     trace_data;
  logic [4:0]      trace_rd;
  logic            trace_we;
  logic [CYCW-1:0] trace_cycle;
  logic [OW-1:0]   occupancy;
  logic [CYCW-1:0] cycle_count;
  logic [31:0]     retired_count;
  logic [15:0]     dropped_count;
  logic            overflow;
  modport master (
    output wb_valid, wb_pc, wb_instruction, wb_write_data, wb_rd_addr, wb_RegWrite,
           clr_overflow, trace_ready,
    input  trace_valid, trace_pc, trace_instruction, trace_data, trace_rd, trace_we,
           trace_cycle, occupancy, cycle_count, retired_count, dropped_count, overflow
  );
  modport slave (
    input  wb_valid, wb_pc, wb_instruction, wb_write_data, wb_rd_addr, wb_RegWrite,
           clr_overflow, trace_ready,
    output trace_valid, trace_pc, trace_instruction, trace_data, trace_rd, trace_we,
           trace_cycle, occupancy, cycle_count, retired_count, dropped_count, overflow
  );
endinterface

// File: rtl/wb_commit_tracer.sv
// wb_commit_tracer: FIFO of retired-instruction records with cycle stamps, streamed out FWFT,
// plus retirement/cycle/drop counters and a sticky overflow flag.
module wb_commit_tracer #(
  parameter int DEPTH = 8,
  parameter int CYCW  = 32
) (
  input logic                clk,
  input logic                reset,
  wb_commit_tracer_if.slave  tr_io
);
  localparam int AW = $clog2(DEPTH);
  localparam int OW = AW + 1;
  typedef struct packed {
    logic [31:0]     pc;
    logic [31:0]     ins;
    logic            we;
    logic [31:0]     data;
    logic [4:0]      rd;
    logic [CYCW-1:0] cyc;
  } rec_t;
  rec_t            mem_q [DEPTH];
  rec_t            wr_rec, hd;
  logic [AW-1:0]   head_q, head_d, tail_q, tail_d;
  logic [OW-1:0]   occ_q, occ_d;
  logic [CYCW-1:0] cyc_q, cyc_d;
  logic [31:0]     ret_q, ret_d;
  logic [15:0]     drop_q, drop_d;
  logic            ovf_q, ovf_d;
  logic            full, valid, pop, push, drop, we;
  always_comb begin
    valid  = occ_q != '0;
    full   = occ_q == OW'(DEPTH);
    pop    = valid && tr_io.trace_ready;
    push   = tr_io.wb_valid && (!full || pop);
    drop   = tr_io.wb_valid && full && !pop;
    we     = tr_io.wb_RegWrite && tr_io.wb_rd_addr != 5'd0;
    wr_rec = {tr_io.wb_pc, tr_io.wb_instruction, we,
              we ? tr_io.wb_write_data : 32'd0, we ? tr_io.wb_rd_addr : 5'd0, cyc_q};
    head_d = pop ? head_q + AW'(1) : head_q;
    tail_d = push ? tail_q + AW'(1) : tail_q;
    occ_d  = occ_q + OW'(push) - OW'(pop);
    cyc_d  = cyc_q + CYCW'(1);
    ret_d  = ret_q + 32'(tr_io.wb_valid);
    drop_d = drop_q + 16'(drop && drop_q != 16'hFFFF);
    // a drop on the same edge as a clear keeps the flag set
    ovf_d  = drop || (ovf_q && !tr_io.clr_overflow);
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      head_q <= '0;
      tail_q <= '0;
      occ_q  <= '0;
      cyc_q  <= '0;
      ret_q  <= '0;
      drop_q <= '0;
      ovf_q  <= 1'b0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      occ_q  <= occ_d;
      cyc_q  <= cyc_d;
      ret_q  <= ret_d;
      drop_q <= drop_d;
      ovf_q  <= ovf_d;
    end
  end
  always_ff @(posedge clk) if (reset && push) mem_q[tail_q] <= wr_rec;
  assign hd                      = valid ? mem_q[head_q] : '0;
  assign tr_io.trace_valid       = valid;
  assign tr_io.trace_pc          = hd.pc;
  assign tr_io.trace_instruction = hd.ins;
  assign tr_io.trace_data        = hd.data;
  assign tr_io.trace_rd          = hd.rd;
  assign tr_io.trace_we          = hd.we;
  assign tr_io.trace_cycle       = hd.cyc;
  assign tr_io.occupancy         = occ_q;
  assign tr_io.cycle_count       = cyc_q;
  assign tr_io.retired_count     = ret_q;
  assign tr_io.dropped_count     = drop_q;
  assign tr_io.overflow          = ovf_q;
endmodule

// File: tb/tb_wb_commit_tracer.sv
// tb_wb_commit_tracer: directed test-plan scenarios plus random traffic against a queue-based model.
module tb_wb_commit_tracer;
  localparam int DEPTH = 8;
  localparam int CYCW  = 32;
  typedef struct {
    logic [31:0] pc, ins, data, cyc;
    logic [4:0]  rd;
    logic        we;
  } mrec_t;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int n_chk = 0;
  int n_fail = 0;
  mrec_t q[$];
  logic [31:0] m_cyc, m_ret;
  logic [15:0] m_drop;
  logic        m_ovf;
  wb_commit_tracer_if #(.DEPTH(DEPTH), .CYCW(CYCW)) tif ();
  wb_commit_tracer #(.DEPTH(DEPTH), .CYCW(CYCW)) dut (.clk(clk), .reset(reset), .tr_io(tif.slave));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic check_all();
    mrec_t h;
    h = '{pc: 0, ins: 0, data: 0, cyc: 0, rd: 0, we: 0};
    if (q.size() != 0) h = q[0];
    chk("valid", tif.trace_valid, q.size() != 0);
    chk("pc", tif.trace_pc, h.pc);
    chk("instr", tif.trace_instruction, h.ins);
    chk("data", tif.trace_data, h.data);
    chk("rd", tif.trace_rd, h.rd);
    chk("we", tif.trace_we, h.we);
    chk("tcycle", tif.trace_cycle, h.cyc);
    chk("occ", tif.occupancy, q.size());
    chk("cycles", tif.cycle_count, m_cyc);
    chk("retired", tif.retired_count, m_ret);
    chk("dropped", tif.dropped_count, m_drop);
    chk("overflow", tif.overflow, m_ovf);
  endtask
  // Applies the current inputs to the model, takes one edge and compares.
  task automatic step();
    mrec_t r;
    bit pop, full, drop;
    if (!reset) begin
      q.delete();
      m_cyc = 0; m_ret = 0; m_drop = 0; m_ovf = 0;
    end else begin
      pop  = q.size() != 0 && tif.trace_ready;
      full = q.size() == DEPTH;
      drop = tif.wb_valid && full && !pop;
      if (pop) void'(q.pop_front());
      if (tif.wb_valid) begin
        m_ret++;
        if (!drop) begin
          r.we   = tif.wb_RegWrite && tif.wb_rd_addr != 0;
          r.pc   = tif.wb_pc;
          r.ins  = tif.wb_instruction;
          r.data = r.we ? tif.wb_write_data : 0;
          r.rd   = r.we ? tif.wb_rd_addr : 0;
          r.cyc  = m_cyc;
          q.push_back(r);
        end else begin
          if (m_drop != 16'hFFFF) m_drop++;
          m_ovf = 1;
        end
      end
      if (tif.clr_overflow && !drop) m_ovf = 0;
      m_cyc++;
    end
    @(posedge clk);
    #1;
    check_all();
  endtask
  task automatic drive(input bit v, input logic [31:0] pc, input logic [31:0] ins,
                       input logic [31:0] data, input logic [4:0] rd, input bit rw,
                       input bit clr, input bit rdy, input bit rst_n);
    tif.wb_valid = v; tif.wb_pc = pc; tif.wb_instruction = ins; tif.wb_write_data = data;
    tif.wb_rd_addr = rd; tif.wb_RegWrite = rw; tif.clr_overflow = clr; tif.trace_ready = rdy;
    reset = rst_n;
    step();
  endtask
  task automatic idle(input bit rdy, input bit rst_n);
    drive(0, $urandom, $urandom, $urandom, 5'($urandom), 1'($urandom), 0, rdy, rst_n);
  endtask
  initial begin
    m_cyc = 0; m_ret = 0; m_drop = 0; m_ovf = 0;
    idle(0, 0);
    idle(0, 0);
    chk("rst_occ", tif.occupancy, 0);
    idle(0, 1);
    idle(0, 1);
    drive(1, 32'h4, 32'h00500093, 32'd5, 5'd1, 1, 0, 0, 1);
    chk("tp1_valid", tif.trace_valid, 1);
    chk("tp1_rd", tif.trace_rd, 1);
    chk("tp1_data", tif.trace_data, 5);
    chk("tp1_we", tif.trace_we, 1);
    chk("tp1_cycle", tif.trace_cycle, 2);
    chk("tp1_ret", tif.retired_count, 1);
    drive(1, 32'h8, 32'h00000013, 32'h1234, 5'd0, 1, 0, 1, 1);
    chk("tp2_we", tif.trace_we, 0);
    chk("tp2_data", tif.trace_data, 0);
    chk("tp2_pc", tif.trace_pc, 32'h8);
    idle(1, 0);
    for (int i = 0; i < DEPTH + 3; i++)
      drive(1, 32'(i * 4), $urandom, $urandom, 5'($urandom), 1, 0, 0, 1);
    chk("tp3_occ", tif.occupancy, 8);
    chk("tp3_drop", tif.dropped_count, 3);
    chk("tp3_ovf", tif.overflow, 1);
    chk("tp3_ret", tif.retired_count, 11);
    drive(1, 32'h100, $urandom, $urandom, 5'd3, 1, 0, 1, 1);
    chk("tp4_occ", tif.occupancy, 8);
    chk("tp4_drop", tif.dropped_count, 3);
    drive(0, 0, 0, 0, 0, 0, 1, 0, 1);
    chk("tp5_clr", tif.overflow, 0);
    chk("tp5_drop", tif.dropped_count, 3);
    drive(1, 32'h200, $urandom, $urandom, 5'd4, 1, 1, 0, 1);
    chk("tp5_setwins", tif.overflow, 1);
    for (int i = 0; i < DEPTH + 2; i++) idle(1, 1);
    for (int i = 0; i < 5; i++) drive(1, $urandom, $urandom, $urandom, 5'($urandom), 1, 0, 0, 1);
    drive(1, $urandom, $urandom, $urandom, 5'd7, 1, 0, 0, 0);
    chk("tp6_occ", tif.occupancy, 0);
    chk("tp6_valid", tif.trace_valid, 0);
    chk("tp6_ret", tif.retired_count, 0);
    for (int i = 0; i < 4000; i++) begin
      int rdy_pct;
      rdy_pct = (i / 500) % 2 ? 90 : 30;
      drive($urandom_range(0, 99) < 70, $urandom, $urandom, $urandom, 5'($urandom), 1'($urandom),
            $urandom_range(0, 9) == 0, $urandom_range(0, 99) < rdy_pct, $urandom_range(0, 299) != 0);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
